// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Define HAZARD_MULDIV_EN for multi-cycle mul/div EXE occupancy; otherwise MULDIV behaves as ALU.
module hazard_forward_ctrl #(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Branch_ID,
   input  logic              rs1use_ID,
   input  logic              rs2use_ID,
   input  logic [2:0]        hazard_optype_ID,
   input  logic [REG_AW-1:0] rs1_ID,
   input  logic [REG_AW-1:0] rs2_ID,
   input  logic [REG_AW-1:0] rs2_EXE,
   input  logic [REG_AW-1:0] rd_EXE,
   input  logic [REG_AW-1:0] rd_MEM,
   output logic              PC_EN_IF,
   output logic              reg_FD_EN,
   output logic              reg_FD_stall,
   output logic              reg_FD_flush,
   output logic              reg_DE_EN,
   output logic              reg_DE_flush,
   output logic              reg_EM_EN,
   output logic              reg_EM_flush,
   output logic              reg_MW_EN,
   output logic [1:0]        forward_ctrl_A,
   output logic [1:0]        forward_ctrl_B,
   output logic              forward_ctrl_ls,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam logic [2:0]       OP_NONE   = 3'd0;
   localparam logic [2:0]       OP_ALU    = 3'd1;
   localparam logic [2:0]       OP_LOAD   = 3'd2;
   localparam logic [2:0]       OP_STORE  = 3'd3;
   localparam logic [2:0]       OP_MULDIV = 3'd4;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       MD_INIT   = 4'(MD_LAT - 1);

   logic [2:0]       opt_exe_q, opt_exe_d;
   logic [2:0]       opt_mem_q, opt_mem_d;
   logic [2:0]       id_op;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic             ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic             load_stall;
   logic             busy;

   // Reserved optype codes collapse to NONE; without the mul/div unit MULDIV is an ALU op.
   always_comb begin
      id_op = hazard_optype_ID;
      if (hazard_optype_ID > OP_MULDIV) begin
         id_op = OP_NONE;
      end
`ifndef HAZARD_MULDIV_EN
      else if (hazard_optype_ID == OP_MULDIV) begin
         id_op = OP_ALU;
      end
`endif
   end

   always_comb begin
      ex_hit_a  = rs1use_ID && (rs1_ID == rd_EXE) && (rd_EXE != '0);
      ex_hit_b  = rs2use_ID && (rs2_ID == rd_EXE) && (rd_EXE != '0);
      mem_hit_a = rs1use_ID && (rs1_ID == rd_MEM) && (rd_MEM != '0);
      mem_hit_b = rs2use_ID && (rs2_ID == rd_MEM) && (rd_MEM != '0);
   end

   function automatic logic [1:0] fwd_code(input logic ex_hit, input logic mem_hit,
                                           input logic [2:0] op_exe, input logic [2:0] op_mem);
      logic [1:0] code;
      code = 2'd0;
      if (ex_hit && (op_exe == OP_ALU)) begin
         code = 2'd1;
      end else if (mem_hit && ((op_mem == OP_ALU) || (op_mem == OP_MULDIV))) begin
         code = 2'd2;
      end else if (mem_hit && (op_mem == OP_LOAD)) begin
         code = 2'd3;
      end
      return code;
   endfunction

   always_comb begin
      forward_ctrl_A  = fwd_code(ex_hit_a, mem_hit_a, opt_exe_q, opt_mem_q);
      forward_ctrl_B  = fwd_code(ex_hit_b, mem_hit_b, opt_exe_q, opt_mem_q);
      forward_ctrl_ls = (rs2_EXE == rd_MEM) && (rd_MEM != '0) &&
                        (opt_exe_q == OP_STORE) && (opt_mem_q == OP_LOAD);
      // A store can take its data from the load in MEM, so it never waits on a load.
      load_stall      = (ex_hit_a || ex_hit_b) &&
                        (((opt_exe_q == OP_LOAD) && (hazard_optype_ID != OP_STORE)) ||
                         (opt_exe_q == OP_MULDIV));
   end

   always_comb begin
      PC_EN_IF     = 1'b1;
      reg_FD_EN    = 1'b1;
      reg_FD_stall = 1'b0;
      reg_FD_flush = Branch_ID;
      reg_DE_EN    = 1'b1;
      reg_DE_flush = 1'b0;
      reg_EM_EN    = 1'b1;
      reg_EM_flush = 1'b0;
      reg_MW_EN    = 1'b1;
      if (busy) begin
         PC_EN_IF     = 1'b0;
         reg_FD_EN    = 1'b0;
         reg_FD_flush = 1'b0;
         reg_DE_EN    = 1'b0;
         reg_EM_flush = 1'b1;
      end else if (load_stall) begin
         PC_EN_IF     = 1'b0;
         reg_FD_stall = 1'b1;
         reg_FD_flush = 1'b0;
         reg_DE_flush = 1'b1;
      end
   end

   // An op occupying EXE holds there and sends bubbles into MEM.
   always_comb begin
      opt_exe_d = opt_exe_q;
      opt_mem_d = OP_NONE;
      if (!busy) begin
         opt_mem_d = opt_exe_q;
         opt_exe_d = reg_DE_flush ? OP_NONE : id_op;
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!PC_EN_IF && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opt_exe_q      <= OP_NONE;
         opt_mem_q      <= OP_NONE;
         stall_cycles_q <= '0;
      end else begin
         opt_exe_q      <= opt_exe_d;
         opt_mem_q      <= opt_mem_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

`ifdef HAZARD_MULDIV_EN
   logic [3:0] md_cnt_q, md_cnt_d;

   assign busy = (md_cnt_q != 4'd0);

   // Reload only when a fresh MULDIV is admitted into EXE, i.e. after the previous count drains.
   always_comb begin
      md_cnt_d = 4'd0;
      if (busy) begin
         md_cnt_d = md_cnt_q - 4'd1;
      end else if (opt_exe_d == OP_MULDIV) begin
         md_cnt_d = MD_INIT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         md_cnt_q <= 4'd0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end
`else
   assign busy = 1'b0;
`endif

   assign md_busy      = busy;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width; ports rd_*, rs*_ are REG_AW bits.
REQ-002 Parameter MD_LAT, default 4: mul/div EXE occupancy in cycles, range 2..15.
REQ-003 Parameter CNT_W, default 32: width of stall_cycles.
REQ-004 clk  input  1  sole clock; rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 Branch_ID, rs1use_ID, rs2use_ID  input  1 each  branch taken in ID; ID reads rs1/rs2.
REQ-007 hazard_optype_ID  input  3  0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 MULDIV; 5-7 treated as NONE.
REQ-008 rs1_ID, rs2_ID, rs2_EXE, rd_EXE, rd_MEM  input  REG_AW each  register addresses.
REQ-009 PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN  output  1 each  pipeline-register controls.
REQ-010 forward_ctrl_A, forward_ctrl_B  output  2 each  0 regfile, 1 EXE ALU, 2 MEM ALU/MULDIV, 3 MEM load data.
REQ-011 forward_ctrl_ls  output  1  store data in EXE taken from load data in MEM.
REQ-012 md_busy  output  1  mul/div occupying EXE.
REQ-013 stall_cycles  output  CNT_W  count of cycles with PC_EN_IF low.

Function
REQ-014 Registers opt_EXE, opt_MEM (3 b) SHALL advance each cycle: opt_MEM<=opt_EXE, opt_EXE<=reg_DE_flush ? NONE : hazard_optype_ID; while md_busy, opt_EXE holds and opt_MEM<=NONE.
REQ-015 Match rule: rsX_ID==rd_S, rd_S!=0, rsXuse_ID=1.
REQ-016 Forward code per operand: EXE match with opt_EXE ALU ->1; else MEM match with opt_MEM ALU or MULDIV ->2; else MEM match with opt_MEM LOAD ->3; else 0; EXE match has priority.
REQ-017 load_stall SHALL assert on EXE match with opt_EXE LOAD and hazard_optype_ID!=STORE, or EXE match with opt_EXE MULDIV (any ID optype).
REQ-018 md_cnt (4 b) SHALL load MD_LAT-1 on cycle where opt_EXE becomes MULDIV, decrement each cycle to 0; md_busy = md_cnt!=0.
REQ-019 While md_busy: PC_EN_IF=0, reg_FD_EN=0, reg_DE_EN=0, reg_EM_flush=1, reg_FD_flush=0, reg_DE_flush=0; forward outputs SHALL still follow REQ-016.
REQ-020 Else while load_stall: PC_EN_IF=0, reg_FD_stall=1, reg_DE_flush=1, reg_FD_flush=0, reg_FD_EN=1.
REQ-021 Else: PC_EN_IF=1, reg_FD_flush=Branch_ID, all other flush/stall 0, all EN 1.
REQ-022 reg_EM_EN and reg_MW_EN SHALL be constant 1.
REQ-023 forward_ctrl_ls = rs2_EXE==rd_MEM, rd_MEM!=0, opt_EXE STORE, opt_MEM LOAD.
REQ-024 stall_cycles SHALL increment when PC_EN_IF=0, saturating at all-ones.
REQ-025 MULDIV issued back-to-back: second op SHALL enter EXE only after md_cnt reaches 0, then reload.

Reset
REQ-026 On rst: opt_EXE=opt_MEM=NONE, md_cnt=0, stall_cycles=0; outputs then equal REQ-021 idle values with forward codes 0.
REQ-027 rst during md_busy SHALL abort the count the next edge; no residual stall.

Configuration
REQ-028 Macro HAZARD_MULDIV_EN: defined -> REQ-018/019/025 behaviour; undefined -> MULDIV treated exactly as ALU (single-cycle, forwardable from EXE with code 1), md_cnt absent, md_busy tied 0.

Verification
REQ-029 opt_EXE ALU rd_EXE=5, ID rs1=5 rs1use=1 -> forward_ctrl_A=1, no stall; rd_EXE=0 -> code 0.
REQ-030 opt_EXE LOAD rd_EXE=7, ID ALU rs2=7 -> one cycle PC_EN_IF=0, reg_DE_flush=1; next cycle forward_ctrl_B=3; stall_cycles +1.
REQ-031 Same load, ID STORE rs2=7 -> no stall; next cycle forward_ctrl_ls=1 with rs2_EXE=7.
REQ-032 MULDIV enters EXE, MD_LAT=4 -> md_busy high 3 cycles, reg_EM_flush=1 and Branch_ID ignored meanwhile; stall_cycles +3.
REQ-033 rst asserted mid md_busy -> next cycle md_busy=0, stall_cycles=0, PC_EN_IF=1.
REQ-034 Build without HAZARD_MULDIV_EN, MULDIV rd_EXE=3, ID rs1=3 -> forward_ctrl_A=1, md_busy=0.
